// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state type, latency defaults and op-class helpers for the MDU.
// Pure declarations: no latency. No backpressure.
// MDU_MADD_EN adds MADD/MADDU to the mult/div class; otherwise ops 9/10 decode as NONE.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Ops that open a busy window and eventually write {HI,LO}.
    function automatic logic is_muldiv(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_muldiv = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU:                  is_muldiv = 1'b1;
`endif
            default:                            is_muldiv = 1'b0;
        endcase
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        is_div = (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Any op that touches HI/LO, used by ID-side decode for id_md_use.
    function automatic logic is_mdu_use(input logic [3:0] op);
        case (op)
            OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: is_mdu_use = 1'b1;
            default:                            is_mdu_use = is_muldiv(op);
        endcase
    endfunction

endpackage

// File: rtl/mdu_if.sv
// EX-stage to MDU bundle: issue command and operands in, busy/stall and HI/LO view out.
// Wiring only: no latency. Backpressure is the stall_req/busy pair.
interface mdu_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        id_md_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    modport master (
        output start, op, rs_data, rt_data, id_md_use,
        input  busy, stall_req, hi, lo, rd_data
    );

    modport slave (
        input  start, op, rs_data, rt_data, id_md_use,
        output busy, stall_req, hi, lo, rd_data
    );
endinterface

// File: rtl/mdu_arith.sv
// Combinational HI/LO result for the latched op: product, quotient/remainder, or accumulate.
// Zero latency. No backpressure; divide by zero returns the current {HI,LO} unchanged.
// MDU_MADD_EN enables the MADD/MADDU accumulate paths.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] hilo_next
);

    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic        [31:0] dvsr;
    logic signed [31:0] squot;
    logic signed [31:0] srem;
    logic        [31:0] uquot;
    logic        [31:0] urem;

    always_comb begin
        sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        uprod = {32'd0, a} * {32'd0, b};
        // Substitute a harmless divisor so the dividers never see zero.
        dvsr  = (b == 32'd0) ? 32'd1 : b;
        squot = $signed(a) / $signed(dvsr);
        srem  = $signed(a) % $signed(dvsr);
        uquot = a / dvsr;
        urem  = a % dvsr;

        hilo_next = {hi, lo};
        case (op)
            OP_MULT:  hilo_next = $unsigned(sprod);
            OP_MULTU: hilo_next = uprod;
            OP_DIV:   if (b != 32'd0) hilo_next = {srem, squot};
            OP_DIVU:  if (b != 32'd0) hilo_next = {urem, uquot};
`ifdef MDU_MADD_EN
            OP_MADD:  hilo_next = {hi, lo} + $unsigned(sprod);
            OP_MADDU: hilo_next = {hi, lo} + uprod;
`endif
            default:  hilo_next = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: issues mult/div ops, runs a fixed busy window, commits HI/LO; MTHI/MTLO write directly.
// Latency: MULT_CYCLES or DIV_CYCLES from issue edge to HI/LO update; rd_data is combinational.
// Backpressure: stall_req holds ID while an MDU op would collide; starts during busy are ignored. Option: MDU_MADD_EN.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  mdu
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

    mdu_state_e       state_q;
    mdu_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [63:0]      hilo_next;

    logic             issue;
    logic             finish;
    logic             wr_hi;
    logic             wr_lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mdu.start && is_muldiv(mdu.op)) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_W'(1))             state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        issue  = 1'b0;
        finish = 1'b0;
        wr_hi  = 1'b0;
        wr_lo  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                issue = mdu.start && is_muldiv(mdu.op);
                wr_hi = mdu.start && (mdu.op == OP_MTHI);
                wr_lo = mdu.start && (mdu.op == OP_MTLO);
            end
            ST_RUN:  finish = (cnt_q == CNT_W'(1));
            default: ;
        endcase
        mdu.busy      = (state_q == ST_RUN);
        mdu.stall_req = mdu.id_md_use &&
                        ((state_q == ST_RUN) || (mdu.start && is_muldiv(mdu.op)));
        mdu.rd_data   = (mdu.op == OP_MFHI) ? hi_q : lo_q;
        mdu.hi        = hi_q;
        mdu.lo        = lo_q;
    end

    // Operands are captured at issue so EX forwarding changes cannot disturb the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            op_q  <= OP_NONE;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            if (issue) begin
                cnt_q <= is_div(mdu.op) ? DIV_LD : MULT_LD;
                op_q  <= mdu.op;
                a_q   <= mdu.rs_data;
                b_q   <= mdu.rt_data;
            end else if (state_q == ST_RUN) begin
                cnt_q <= finish ? '0 : cnt_q - CNT_W'(1);
            end

            if (finish) begin
                {hi_q, lo_q} <= hilo_next;
            end else begin
                if (wr_hi) hi_q <= mdu.rs_data;
                if (wr_lo) lo_q <= mdu.rs_data;
            end
        end
    end

    mdu_arith u_arith (
        .op        (op_q),
        .a         (a_q),
        .b         (b_q),
        .hi        (hi_q),
        .lo        (lo_q),
        .hilo_next (hilo_next)
    );

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: a countdown/arithmetic model checked every negedge, plus literal expectations.
module tb_mdu_ctrl;

    localparam logic [3:0] N_NONE = 4'd0, N_MULT = 4'd1, N_MULTU = 4'd2, N_DIV = 4'd3,
                           N_DIVU = 4'd4, N_MTHI = 4'd5, N_MTLO = 4'd6, N_MFHI = 4'd7,
                           N_MFLO = 4'd8, N_MADD = 4'd9, N_MADDU = 4'd10;
    localparam int M_CYC = 5;
    localparam int D_CYC = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    mdu_if bus ();

    mdu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (bus)
    );

    always #5 clk = ~clk;

    // Model state: architectural HI/LO, remaining busy cycles, and the pending op.
    logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
    logic [3:0]  m_op = '0;
    int          m_left = 0;

    function automatic logic m_class(input logic [3:0] o);
`ifdef MDU_MADD_EN
        return (o >= N_MULT && o <= N_DIVU) || o == N_MADD || o == N_MADDU;
`else
        return (o >= N_MULT && o <= N_DIVU);
`endif
    endfunction

    function automatic logic [63:0] m_calc(input logic [3:0] o, input logic [31:0] a, b,
                                           input logic [63:0] acc);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              da, db;
        sa = $signed(a); sb = $signed(b);
        ua = a; ub = b;
        da = a; db = b;
        case (o)
            N_MULT:  return sa * sb;
            N_MULTU: return ua * ub;
            N_DIV:   return (b == 0) ? acc : {32'(da % db), 32'(da / db)};
            N_DIVU:  return (b == 0) ? acc : {a % b, a / b};
            N_MADD:  return acc + sa * sb;
            N_MADDU: return acc + ua * ub;
            default: return acc;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_left = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) {m_hi, m_lo} = m_calc(m_op, m_a, m_b, {m_hi, m_lo});
        end else if (bus.start) begin
            if (m_class(bus.op)) begin
                m_op = bus.op; m_a = bus.rs_data; m_b = bus.rt_data;
                m_left = (bus.op == N_DIV || bus.op == N_DIVU) ? D_CYC : M_CYC;
            end else if (bus.op == N_MTHI) begin
                m_hi = bus.rs_data;
            end else if (bus.op == N_MTLO) begin
                m_lo = bus.rs_data;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(m_left > 0));
        chk("stall_req", 32'(bus.stall_req),
            32'(bus.id_md_use && ((m_left > 0) || (bus.start && m_class(bus.op)))));
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
        chk("rd_data", bus.rd_data, (bus.op == N_MFHI) ? m_hi : m_lo);
        if (!reset && bus.start && m_left > 0 && m_class(bus.op)) begin
            fails++;
            $display("FAIL illegal_start: op %0d issued while busy at %0t", bus.op, $time);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input string name, input logic [3:0] o, input logic [31:0] a, b,
                         input logic md, input logic exp_stall);
        bus.start = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b; bus.id_md_use = md;
        #1 chk({name, "_stall"}, 32'(bus.stall_req), 32'(exp_stall));
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = N_NONE;
        bus.rs_data = $urandom; bus.rt_data = $urandom;
    endtask

    task automatic wait_done(input string name, input int exp_n);
        int n = 0;
        while (bus.busy && n < 100) begin
            n++;
            tick(1);
        end
        chk({name, "_busy_cycles"}, 32'(n), 32'(exp_n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.op = N_NONE; bus.rs_data = '0; bus.rt_data = '0; bus.id_md_use = 1'b0;
        #1 reset = 1'b1;
        tick(2);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_stall", 32'(bus.stall_req), 32'h0);
        reset = 1'b0;
        tick(1);

        issue("mult", N_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        wait_done("mult", 5);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFF1);

        issue("divu", N_DIVU, 32'd17, 32'd5, 1'b0, 1'b0);
        wait_done("divu", 10);
        chk("divu_lo", bus.lo, 32'd3);
        chk("divu_hi", bus.hi, 32'd2);

        issue("div", N_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        wait_done("div", 10);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);

        issue("mthi", N_MTHI, 32'h11, 32'h0, 1'b0, 1'b0);
        issue("mtlo", N_MTLO, 32'h22, 32'h0, 1'b0, 1'b0);
        chk("mt_busy", 32'(bus.busy), 32'h0);
        issue("div0", N_DIV, 32'h1234, 32'h0, 1'b0, 1'b0);
        wait_done("div0", 10);
        chk("div0_hi", bus.hi, 32'h11);
        chk("div0_lo", bus.lo, 32'h22);

        issue("stall_mult", N_MULT, 32'd6, 32'd7, 1'b1, 1'b1);
        chk("stall_busy", 32'(bus.stall_req), 32'h1);
        wait_done("stall_mult", 5);
        chk("stall_after", 32'(bus.stall_req), 32'h0);
        chk("stall_mult_lo", bus.lo, 32'd42);
        bus.id_md_use = 1'b0;

        issue("mthi2", N_MTHI, 32'hABCD, 32'h0, 1'b0, 1'b0);
        bus.start = 1'b1; bus.op = N_MFHI;
        #1 chk("mfhi", bus.rd_data, 32'hABCD);
        bus.op = N_MFLO;
        #1 chk("mflo", bus.rd_data, 32'd42);
        tick(1);
        bus.start = 1'b0; bus.op = N_NONE;

        issue("multu", N_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_done("multu", 5);
        chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_lo", bus.lo, 32'h0000_0001);

        issue("abort", N_MULT, 32'd3, 32'd4, 1'b0, 1'b0);
        tick(2);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_hi", bus.hi, 32'h0);
        chk("abort_lo", bus.lo, 32'h0);
        tick(1);
        reset = 1'b0;
        tick(8);
        chk("abort_late_hi", bus.hi, 32'h0);
        chk("abort_late_lo", bus.lo, 32'h0);

        issue("madd_hi", N_MTHI, 32'h0, 32'h0, 1'b0, 1'b0);
        issue("madd_lo", N_MTLO, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
`ifdef MDU_MADD_EN
        issue("maddu", N_MADDU, 32'd1, 32'd1, 1'b1, 1'b1);
        wait_done("maddu", 5);
        chk("maddu_hi", bus.hi, 32'h1);
        chk("maddu_lo", bus.lo, 32'h0);
`else
        issue("maddu", N_MADDU, 32'd1, 32'd1, 1'b1, 1'b0);
        chk("maddu_busy", 32'(bus.busy), 32'h0);
        tick(6);
        chk("maddu_hi", bus.hi, 32'h0);
        chk("maddu_lo", bus.lo, 32'hFFFF_FFFF);
`endif
        bus.id_md_use = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the five-stage MIPS pipeline, sitting in EX beside the ALU. It accepts mult/div/mthi/mtlo issues from EX, sequences a fixed multi-cycle busy window per operation, and commits results into the HI/LO registers. It serves mfhi/mflo reads and drives the stall request that holds ID while an MDU instruction would collide with an in-flight operation.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  EX holds a valid MDU instruction this cycle
- op  in  4  operation code from mdu_pkg
- rs_data  in  32  operand A, forwarded value
- rt_data  in  32  operand B, forwarded value
- id_md_use  in  1  instruction in ID is any MDU op
- busy  out  1  operation in flight
- stall_req  out  1  hold PC/IF-ID, bubble ID-EX
- hi  out  32  HI register
- lo  out  32  LO register
- rd_data  out  32  mfhi/mflo result, combinational

## Operation
- Op codes: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9 MADD, 10 MADDU; any other code behaves as NONE.
- FSM has two states, IDLE and RUN.
  - IDLE: start with a mult/div-class op latches the operands and op, loads cnt with N = MULT_CYCLES or DIV_CYCLES, and enters RUN.
  - RUN: cnt decrements every cycle. The edge at which cnt==1 writes the result to {HI,LO}, clears cnt, and returns to IDLE.
- Arithmetic:
  - mult/madd are 64-bit signed; multu/maddu are unsigned.
  - div/divu: LO = quotient, HI = remainder, truncated toward zero with remainder sign following the dividend.
  - Divisor 0: HI/LO are left unchanged, and busy still runs the full DIV_CYCLES.
- MTHI/MTLO with start in IDLE write hi/lo at that edge. They have no busy window.
- rd_data = hi when op==MFHI, else lo. It reads the current register value.
- busy = (state==RUN).
- stall_req = id_md_use & (busy | (start & op is mult/div-class)).
- start while busy is ignored. This is illegal because stall_req prevents it, and the bench flags it.

## Timing
- Reset: state IDLE, cnt 0, busy 0, stall_req 0 unless combinationally driven, hi 0, lo 0, latched operands 0.
- start sampled at edge E0: busy is 1 from E0 through the cycle ending at edge E0+N. HI/LO take the new value at E0+N, and busy is 0 after E0+N.
- mfhi in EX while busy cannot occur, because ID was stalled.
- Reset asserted mid-operation aborts immediately, with no partial HI/LO write.
- Operands are latched at E0, so later changes to rs_data/rt_data have no effect.

## Configuration
- MDU_MADD_EN defined: MADD/MADDU are decoded and {HI,LO} += product at completion, modulo 2^64.
- MDU_MADD_EN undefined: op 9/10 are treated as NONE. They start nothing and do not count toward stall_req.

## Structure
- mdu_pkg holds the op localparams/typedef, the is_muldiv and is_mdu_use helper functions, and default latency constants.
- Sub-module mdu_arith is purely combinational. It takes the latched operands and op and produces the 64-bit {hi_next, lo_next}, including the divide-by-zero hold and the madd accumulate.
- mdu_ctrl holds the FSM, counter, registers and stall logic.

## Test plan
- MULT rs=0xFFFFFFFD (-3), rt=5: busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU 17/5: busy for 10 cycles, then LO=3, HI=2. DIV -7/2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV x/0 with HI=0x11, LO=0x22 beforehand: busy for 10 cycles, and HI/LO stay 0x11/0x22.
- MULT start with id_md_use=1: stall_req=1 in the start cycle and every busy cycle, then 0 the cycle after completion. MTHI 0xABCD followed by MFHI gives rd_data=0xABCD.
- Reset asserted in the 3rd busy cycle: busy=0 and hi=lo=0 immediately, and no later write occurs.
- With MDU_MADD_EN, HI=0, LO=0xFFFFFFFF, MADDU 1*1: HI=1, LO=0. Without MDU_MADD_EN, the same op leaves busy=0 and HI/LO unchanged.
